// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use hazard detection and event counters
module id_ex_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_val_a,
   input  logic [XLEN-1:0]  id_val_b,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [2:0]       id_funct3,
   input  logic             id_funct7_5,
   input  logic             id_mem_rd,
   input  logic             id_mem_wr,
   input  logic             id_reg_wr,
   input  logic             id_mux_reg_wr,
   input  logic             id_jump,
   input  logic             id_branch,
   input  logic             id_jalr,
   input  logic [1:0]       id_ula_op,
   input  logic [1:0]       id_alu_src1,
   input  logic [1:0]       id_alu_src2,

   input  logic             ex_flush,

   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_val_a,
   output logic [XLEN-1:0]  ex_val_b,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic             ex_uses_rs1,
   output logic             ex_uses_rs2,
   output logic [2:0]       ex_funct3,
   output logic             ex_funct7_5,
   output logic             ex_mem_rd,
   output logic             ex_mem_wr,
   output logic             ex_reg_wr,
   output logic             ex_mux_reg_wr,
   output logic             ex_jump,
   output logic             ex_branch,
   output logic             ex_jalr,
   output logic [1:0]       ex_ula_op,
   output logic [1:0]       ex_alu_src1,
   output logic [1:0]       ex_alu_src2,

   output logic             stall_out,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic rs1_match;
   logic rs2_match;
   logic hz;
   logic capture;

   // A load in EX whose destination is read by the instruction in ID; x0 never counts.
   always_comb begin
      rs1_match = id_uses_rs1 & (id_rs1 == ex_rd);
      rs2_match = id_uses_rs2 & (id_rs2 == ex_rd);
      hz        = ex_valid & ex_mem_rd & (ex_rd != 5'd0) & id_valid & (rs1_match | rs2_match);
      stall_out = hz & ~ex_flush;
      capture   = id_valid & ~hz & ~ex_flush;
   end

   // Anything other than a clean capture loads the all-zero bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_pc         <= '0;
         ex_val_a      <= '0;
         ex_val_b      <= '0;
         ex_imm        <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
         ex_uses_rs1   <= 1'b0;
         ex_uses_rs2   <= 1'b0;
         ex_funct3     <= '0;
         ex_funct7_5   <= 1'b0;
         ex_mem_rd     <= 1'b0;
         ex_mem_wr     <= 1'b0;
         ex_reg_wr     <= 1'b0;
         ex_mux_reg_wr <= 1'b0;
         ex_jump       <= 1'b0;
         ex_branch     <= 1'b0;
         ex_jalr       <= 1'b0;
         ex_ula_op     <= '0;
         ex_alu_src1   <= '0;
         ex_alu_src2   <= '0;
      end else begin
         ex_valid      <= capture;
         ex_pc         <= capture ? id_pc       : '0;
         ex_val_a      <= capture ? id_val_a    : '0;
         ex_val_b      <= capture ? id_val_b    : '0;
         ex_imm        <= capture ? id_imm      : '0;
         ex_rs1        <= capture ? id_rs1      : '0;
         ex_rs2        <= capture ? id_rs2      : '0;
         ex_rd         <= capture ? id_rd       : '0;
         ex_uses_rs1   <= capture & id_uses_rs1;
         ex_uses_rs2   <= capture & id_uses_rs2;
         ex_funct3     <= capture ? id_funct3   : '0;
         ex_funct7_5   <= capture & id_funct7_5;
         ex_mem_rd     <= capture & id_mem_rd;
         ex_mem_wr     <= capture & id_mem_wr;
         ex_reg_wr     <= capture & id_reg_wr;
         ex_mux_reg_wr <= capture & id_mux_reg_wr;
         ex_jump       <= capture & id_jump;
         ex_branch     <= capture & id_branch;
         ex_jalr       <= capture & id_jalr;
         ex_ula_op     <= capture ? id_ula_op   : '0;
         ex_alu_src1   <= capture ? id_alu_src1 : '0;
         ex_alu_src2   <= capture ? id_alu_src2 : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_out && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (ex_flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - randomized and directed self-checking bench for id_ex_reg
module tb_id_ex_reg;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] val_a;
      logic [31:0] val_b;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        uses_rs1;
      logic        uses_rs2;
      logic [2:0]  funct3;
      logic        funct7_5;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
      logic        mux_reg_wr;
      logic        jump;
      logic        branch;
      logic        jalr;
      logic [1:0]  ula_op;
      logic [1:0]  alu_src1;
      logic [1:0]  alu_src2;
   } bundle_t;

   logic    clk = 1'b0;
   logic    rst;
   logic    ex_flush;
   bundle_t id_b;

   always #5 clk = ~clk;

   logic        ex_valid, ex_uses_rs1, ex_uses_rs2, ex_funct7_5;
   logic [31:0] ex_pc, ex_val_a, ex_val_b, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_jump, ex_branch, ex_jalr;
   logic [1:0]  ex_ula_op, ex_alu_src1, ex_alu_src2;
   logic        stall_out;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_valid, s_uses_rs1, s_uses_rs2, s_funct7_5;
   logic [31:0] s_pc, s_val_a, s_val_b, s_imm;
   logic [4:0]  s_rs1, s_rs2, s_rd;
   logic [2:0]  s_funct3;
   logic        s_mem_rd, s_mem_wr, s_reg_wr, s_mux_reg_wr, s_jump, s_branch, s_jalr;
   logic [1:0]  s_ula_op, s_alu_src1, s_alu_src2;
   logic        s_stall_out;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   bundle_t ex_b, s_b;
   assign ex_b = {ex_valid, ex_pc, ex_val_a, ex_val_b, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_uses_rs1, ex_uses_rs2, ex_funct3, ex_funct7_5, ex_mem_rd, ex_mem_wr,
                  ex_reg_wr, ex_mux_reg_wr, ex_jump, ex_branch, ex_jalr, ex_ula_op,
                  ex_alu_src1, ex_alu_src2};
   assign s_b  = {s_valid, s_pc, s_val_a, s_val_b, s_imm, s_rs1, s_rs2, s_rd,
                  s_uses_rs1, s_uses_rs2, s_funct3, s_funct7_5, s_mem_rd, s_mem_wr,
                  s_reg_wr, s_mux_reg_wr, s_jump, s_branch, s_jalr, s_ula_op,
                  s_alu_src1, s_alu_src2};

   id_ex_reg #(.XLEN(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_b.valid), .id_pc(id_b.pc), .id_val_a(id_b.val_a),
      .id_val_b(id_b.val_b), .id_imm(id_b.imm), .id_rs1(id_b.rs1), .id_rs2(id_b.rs2),
      .id_rd(id_b.rd), .id_uses_rs1(id_b.uses_rs1), .id_uses_rs2(id_b.uses_rs2),
      .id_funct3(id_b.funct3), .id_funct7_5(id_b.funct7_5), .id_mem_rd(id_b.mem_rd),
      .id_mem_wr(id_b.mem_wr), .id_reg_wr(id_b.reg_wr), .id_mux_reg_wr(id_b.mux_reg_wr),
      .id_jump(id_b.jump), .id_branch(id_b.branch), .id_jalr(id_b.jalr),
      .id_ula_op(id_b.ula_op), .id_alu_src1(id_b.alu_src1), .id_alu_src2(id_b.alu_src2),
      .ex_flush(ex_flush),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val_a(ex_val_a), .ex_val_b(ex_val_b),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2), .ex_funct3(ex_funct3),
      .ex_funct7_5(ex_funct7_5), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_reg_wr(ex_reg_wr), .ex_mux_reg_wr(ex_mux_reg_wr), .ex_jump(ex_jump),
      .ex_branch(ex_branch), .ex_jalr(ex_jalr), .ex_ula_op(ex_ula_op),
      .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
      .stall_out(stall_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Narrow-counter instance to observe saturation quickly.
   id_ex_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_b.valid), .id_pc(id_b.pc), .id_val_a(id_b.val_a),
      .id_val_b(id_b.val_b), .id_imm(id_b.imm), .id_rs1(id_b.rs1), .id_rs2(id_b.rs2),
      .id_rd(id_b.rd), .id_uses_rs1(id_b.uses_rs1), .id_uses_rs2(id_b.uses_rs2),
      .id_funct3(id_b.funct3), .id_funct7_5(id_b.funct7_5), .id_mem_rd(id_b.mem_rd),
      .id_mem_wr(id_b.mem_wr), .id_reg_wr(id_b.reg_wr), .id_mux_reg_wr(id_b.mux_reg_wr),
      .id_jump(id_b.jump), .id_branch(id_b.branch), .id_jalr(id_b.jalr),
      .id_ula_op(id_b.ula_op), .id_alu_src1(id_b.alu_src1), .id_alu_src2(id_b.alu_src2),
      .ex_flush(ex_flush),
      .ex_valid(s_valid), .ex_pc(s_pc), .ex_val_a(s_val_a), .ex_val_b(s_val_b),
      .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
      .ex_uses_rs1(s_uses_rs1), .ex_uses_rs2(s_uses_rs2), .ex_funct3(s_funct3),
      .ex_funct7_5(s_funct7_5), .ex_mem_rd(s_mem_rd), .ex_mem_wr(s_mem_wr),
      .ex_reg_wr(s_reg_wr), .ex_mux_reg_wr(s_mux_reg_wr), .ex_jump(s_jump),
      .ex_branch(s_branch), .ex_jalr(s_jalr), .ex_ula_op(s_ula_op),
      .ex_alu_src1(s_alu_src1), .ex_alu_src2(s_alu_src2),
      .stall_out(s_stall_out), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   bundle_t     m_ex;
   int unsigned m_stall;
   int unsigned m_flush;
   logic        m_ready = 1'b0;
   logic        last_stall;

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic m_hz(input bundle_t id);
      return m_ex.valid && m_ex.mem_rd && (m_ex.rd != 5'd0) && id.valid &&
             ((id.uses_rs1 && id.rs1 == m_ex.rd) || (id.uses_rs2 && id.rs2 == m_ex.rd));
   endfunction

   function automatic logic [191:0] sat(input int unsigned n, input int unsigned w);
      int unsigned lim;
      lim = (1 << w) - 1;
      return (n > lim) ? 192'(lim) : 192'(n);
   endfunction

   function automatic bundle_t rand_bundle();
      logic [191:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return bundle_t'(r[$bits(bundle_t)-1:0]);
   endfunction

   function automatic bundle_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u1, input logic u2, input logic mrd,
                                  input logic mwr, input logic rwr);
      bundle_t b;
      b = '0;
      b.valid = 1'b1; b.pc = 32'h200; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
      b.uses_rs1 = u1; b.uses_rs2 = u2; b.mem_rd = mrd; b.mem_wr = mwr;
      b.reg_wr = rwr; b.mux_reg_wr = mrd; b.val_a = 32'h1111; b.val_b = 32'h2222;
      return b;
   endfunction

   // One cycle: drive at the falling edge, check stall_out, clock, then check registered state.
   task automatic step(input bundle_t id, input logic flush, input logic r);
      logic hz, exp_stall;
      id_b = id; ex_flush = flush; rst = r;
      #1;
      hz = m_hz(id);
      exp_stall = hz & ~flush;
      last_stall = stall_out;
      if (m_ready) check("stall_out", {191'd0, stall_out}, {191'd0, exp_stall});
      @(posedge clk);
      if (r) begin
         m_ex = '0; m_stall = 0; m_flush = 0; m_ready = 1'b1;
      end else begin
         if (exp_stall) m_stall++;
         if (flush) m_flush++;
         if (flush || hz || !id.valid) m_ex = '0;
         else begin
            m_ex = id;
            m_ex.valid = 1'b1;
         end
      end
      @(negedge clk);
      check("ex_state", 192'(ex_b), 192'(m_ex));
      check("sat_ex_state", 192'(s_b), 192'(m_ex));
      check("stall_cnt", 192'(stall_cnt), sat(m_stall, 16));
      check("flush_cnt", 192'(flush_cnt), sat(m_flush, 16));
      check("sat_stall_cnt", 192'(s_stall_cnt), sat(m_stall, 2));
      check("sat_flush_cnt", 192'(s_flush_cnt), sat(m_flush, 2));
   endtask

   initial begin
      bundle_t lw, add, a, sw, cur;
      logic fl, rr;
      id_b = '0; ex_flush = 1'b0; rst = 1'b1; last_stall = 1'b0;
      m_ex = '0; m_stall = 0; m_flush = 0;
      @(negedge clk);

      step(rand_bundle(), 1'b0, 1'b1);
      step(rand_bundle(), 1'b0, 1'b1);
      check("rst_valid", 192'(ex_valid), 192'd0);
      check("rst_stall_out", 192'(stall_out), 192'd0);

      a = mk(5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      a.alu_src2 = 2'b01; a.imm = 32'd5; a.pc = 32'h100;
      step(a, 1'b0, 1'b0);
      check("addi_rd", 192'(ex_rd), 192'd3);
      check("addi_imm", 192'(ex_imm), 192'd5);
      check("addi_pc", 192'(ex_pc), 192'h100);
      check("addi_valid", 192'(ex_valid), 192'd1);
      check("addi_src2", 192'(ex_alu_src2), 192'd1);

      lw  = mk(5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      add = mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(rand_bundle(), 1'b0, 1'b1);
      step(lw, 1'b0, 1'b0);
      step(add, 1'b0, 1'b0);
      check("lu_stall", 192'(last_stall), 192'd1);
      check("lu_bubble_valid", 192'(ex_valid), 192'd0);
      check("lu_bubble_ctrl", 192'({ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_jump}), 192'd0);
      step(add, 1'b0, 1'b0);
      check("lu_stall_drop", 192'(last_stall), 192'd0);
      check("lu_capture_rd", 192'(ex_rd), 192'd6);
      check("lu_stall_cnt", 192'(stall_cnt), 192'd1);

      step(mk(5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0);
      step(mk(5'd6, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
      check("x0_no_stall", 192'(last_stall), 192'd0);
      step(lw, 1'b0, 1'b0);
      step(mk(5'd7, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
      check("lui_no_stall", 192'(last_stall), 192'd0);
      check("lui_valid", 192'(ex_valid), 192'd1);

      step(rand_bundle(), 1'b0, 1'b1);
      step(lw, 1'b0, 1'b0);
      step(add, 1'b1, 1'b0);
      check("fvs_stall", 192'(last_stall), 192'd0);
      check("fvs_bubble", 192'(ex_valid), 192'd0);
      check("fvs_flush_cnt", 192'(flush_cnt), 192'd1);
      check("fvs_stall_cnt", 192'(stall_cnt), 192'd0);

      sw = mk(5'd0, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(sw, 1'b1, 1'b0);
      check("sw_flush_memwr", 192'(ex_mem_wr), 192'd0);
      step(sw, 1'b0, 1'b0);
      check("sw_capture_memwr", 192'(ex_mem_wr), 192'd1);

      step(rand_bundle(), 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(rand_bundle(), 1'b1, 1'b0);
      check("sat_flush_hold", 192'(s_flush_cnt), 192'd3);
      check("wide_flush_5", 192'(flush_cnt), 192'd5);

      cur = rand_bundle();
      for (int i = 0; i < 400; i++) begin
         if (!(last_stall && !rst)) begin
            cur = rand_bundle();
            cur.valid = ($urandom_range(7) != 0);
            if ($urandom_range(1) == 1) cur.rs1 = m_ex.rd;
            if ($urandom_range(2) == 0) cur.rs2 = m_ex.rd;
            cur.mem_rd = ($urandom_range(2) == 0);
         end
         fl = ($urandom_range(7) == 0);
         rr = ($urandom_range(63) == 0);
         step(cur, fl, rr);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
